// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter with per-requester lock that shares one pipelined fp_add among N_REQ requesters.
// Optional macro FP_ADD_ARB_STATS_EN adds saturating issue/stall counters.
`ifndef FP_ADD_LAT
`define FP_ADD_LAT 4
`endif

module fp_add_arbiter #(
  parameter int N_REQ = 4,
  parameter int LAT   = `FP_ADD_LAT,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     req_lock,
  input  logic [32*N_REQ-1:0]  req_a,
  input  logic [32*N_REQ-1:0]  req_b,
  input  logic [N_REQ-1:0]     req_sub,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     rsp_val,
  output logic [31:0]          rsp_data,
  output logic [ID_W-1:0]      rsp_id,
  output logic [31:0]          add_a,
  output logic [31:0]          add_b,
  output logic                 add_sub,
  output logic                 add_en,
  input  logic [31:0]          add_y,
  output logic                 busy
`ifdef FP_ADD_ARB_STATS_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          issue_cnt
`endif
);

  logic [31:0]     a_arr [N_REQ];
  logic [31:0]     b_arr [N_REQ];
  logic [ID_W-1:0] prio_reg;
  logic            locked_reg;
  logic [ID_W-1:0] lock_id_reg;
  logic            lock_hit;
  logic            any_req;
  logic            issue;
  logic [ID_W-1:0] gnt_id;
  logic [ID_W-1:0] cand;
  logic [LAT-1:0]  tag_vld_reg;
  logic [ID_W-1:0] tag_id_reg [LAT];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign a_arr[gi] = req_a[32*gi +: 32];
      assign b_arr[gi] = req_b[32*gi +: 32];
    end
  endgenerate

  // Descending scan so the candidate closest to prio_reg is the last writer and wins.
  always_comb begin
    lock_hit = locked_reg && req[lock_id_reg];
    any_req  = 1'b0;
    gnt_id   = '0;
    cand     = '0;
    if (lock_hit) begin
      any_req = 1'b1;
      gnt_id  = lock_id_reg;
    end else begin
      for (int k = N_REQ - 1; k >= 0; k--) begin
        cand = ID_W'((int'(prio_reg) + k) % N_REQ);
        if (req[cand]) begin
          any_req = 1'b1;
          gnt_id  = cand;
        end
      end
    end
  end

  assign issue   = any_req && !rst;
  assign gnt     = issue ? (N_REQ'(1) << gnt_id) : '0;
  assign add_en  = issue;
  assign add_a   = a_arr[gnt_id];
  assign add_b   = b_arr[gnt_id];
  assign add_sub = req_sub[gnt_id];

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_reg    <= '0;
      locked_reg  <= 1'b0;
      lock_id_reg <= '0;
    end else if (issue) begin
      if (!lock_hit)
        prio_reg <= (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
      locked_reg  <= req_lock[gnt_id];
      lock_id_reg <= gnt_id;
    end else if (locked_reg && !req[lock_id_reg]) begin
      // Idle locker gives up the lock so others cannot be starved.
      locked_reg <= 1'b0;
    end
  end

  // Owner tags travel alongside the adder pipeline; results come back in issue order.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_reg <= '0;
      for (int i = 0; i < LAT; i++) tag_id_reg[i] <= '0;
    end else begin
      tag_vld_reg[0] <= issue;
      tag_id_reg[0]  <= gnt_id;
      for (int i = 1; i < LAT; i++) begin
        tag_vld_reg[i] <= tag_vld_reg[i-1];
        tag_id_reg[i]  <= tag_id_reg[i-1];
      end
    end
  end

  assign rsp_val  = (tag_vld_reg[LAT-1] && !rst) ? (N_REQ'(1) << tag_id_reg[LAT-1]) : '0;
  assign rsp_id   = tag_id_reg[LAT-1];
  assign rsp_data = add_y;
  assign busy     = |tag_vld_reg;

`ifdef FP_ADD_ARB_STATS_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] issue_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
      issue_cnt_reg <= '0;
    end else begin
      if (add_en && issue_cnt_reg != 32'hFFFF_FFFF)
        issue_cnt_reg <= issue_cnt_reg + 32'd1;
      if ((|(req & ~gnt)) && stall_cnt_reg != 32'hFFFF_FFFF)
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign issue_cnt = issue_cnt_reg;
`endif

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: directed vector table, reset/lock sequences and random traffic
// checked against a queue-based reference model; a behavioural fp_add sits behind the arbiter.
module tb_fp_add_arbiter;
  localparam int N   = 4;
  localparam int LAT = 4;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, req_lock, req_sub;
  logic [32*N-1:0] req_a, req_b;
  logic [N-1:0]    gnt, rsp_val;
  logic [31:0]     rsp_data, add_a, add_b, add_y;
  logic [IDW-1:0]  rsp_id;
  logic            add_sub, add_en, busy;
`ifdef FP_ADD_ARB_STATS_EN
  logic [31:0]     stall_cnt, issue_cnt;
`endif

  always #5 clk = ~clk;

  fp_add_arbiter #(.N_REQ(N), .LAT(LAT), .ID_W(IDW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_lock(req_lock), .req_a(req_a), .req_b(req_b),
    .req_sub(req_sub), .gnt(gnt), .rsp_val(rsp_val), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .add_a(add_a), .add_b(add_b), .add_sub(add_sub), .add_en(add_en), .add_y(add_y),
    .busy(busy)
`ifdef FP_ADD_ARB_STATS_EN
    , .stall_cnt(stall_cnt), .issue_cnt(issue_cnt)
`endif
  );

  // Single-precision <-> real helpers, exact for normal numbers and zero.
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    logic [10:0] e;
    if (f[30:0] == 31'd0) d = {f[31], 63'd0};
    else begin
      e = {3'b000, f[30:23]} + 11'd896;
      d = {f[31], e, f[22:0], 29'd0};
    end
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b, input logic s);
    real r;
    r = s ? (f2r(a) - f2r(b)) : (f2r(a) + f2r(b));
    return r2f(r);
  endfunction

  // Behavioural fp_add with LAT cycles from en to y.
  logic [31:0] fa_pipe [LAT];
  always @(posedge clk) begin
    fa_pipe[0] <= add_en ? fadd(add_a, add_b, add_sub) : 32'hDEAD_BEEF;
    for (int i = 1; i < LAT; i++) fa_pipe[i] <= fa_pipe[i-1];
  end
  assign add_y = fa_pipe[LAT-1];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: round-robin pointer, lock state and a queue of results due by cycle.
  typedef struct { int due; int id; logic [31:0] data; } exp_t;
  exp_t q[$];
  int   m_prio = 0;
  bit   m_locked = 0;
  int   m_lock_id = 0;

  task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] lk, input logic rs,
                       input logic [N-1:0] eg, input bit use_eg);
    logic [N-1:0] mg;
    logic [N-1:0] ev;
    int g;
    bit lock_grant;
    req = r; req_lock = lk; rst = rs;
    #2;
    g = -1;
    lock_grant = 0;
    if (!rs) begin
      if (m_locked && r[m_lock_id]) begin
        g = m_lock_id;
        lock_grant = 1;
      end else begin
        for (int k = 0; k < N; k++)
          if (g < 0 && r[(m_prio + k) % N]) g = (m_prio + k) % N;
      end
    end
    mg = '0;
    if (g >= 0) mg[g] = 1'b1;
    chk("gnt", 32'(gnt), 32'(mg));
    chk("add_en", 32'(add_en), 32'(g >= 0));
    if (g >= 0) begin
      chk("add_a", add_a, req_a[32*g +: 32]);
      chk("add_b", add_b, req_b[32*g +: 32]);
      chk("add_sub", 32'(add_sub), 32'(req_sub[g]));
    end
    if (use_eg) chk("gnt_tbl", 32'(gnt), 32'(eg));
    chk("busy", 32'(busy), 32'(q.size() != 0));
    ev = '0;
    if (!rs && q.size() > 0 && q[0].due == cyc) ev[q[0].id] = 1'b1;
    chk("rsp_val", 32'(rsp_val), 32'(ev));
    if (ev != '0) begin
      chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
      chk("rsp_data", rsp_data, q[0].data);
      $display("cycle %0d: result id=%0d data=%h", cyc, rsp_id, rsp_data);
      void'(q.pop_front());
    end
    @(posedge clk);
    if (rs) begin
      q.delete();
      m_prio = 0; m_locked = 0; m_lock_id = 0;
    end else if (g >= 0) begin
      q.push_back('{cyc + LAT, g, fadd(req_a[32*g +: 32], req_b[32*g +: 32], req_sub[g])});
      if (!lock_grant) m_prio = (g + 1) % N;
      m_locked = lk[g];
      m_lock_id = g;
    end else if (m_locked && !r[m_lock_id]) begin
      m_locked = 0;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, '0, 1'b0, '0, 1'b0);
  endtask

  typedef struct { logic [N-1:0] r; logic [N-1:0] lk; logic [N-1:0] g; } vec_t;
  vec_t tbl [18];

  initial begin
    // Round robin with all four requesting, then lock hold/release sequences.
    for (int i = 0; i < 8; i++) tbl[i] = '{4'b1111, 4'b0000, 4'(1 << (i % 4))};
    tbl[8]  = '{4'b0011, 4'b0001, 4'b0001};
    tbl[9]  = '{4'b0011, 4'b0001, 4'b0001};
    tbl[10] = '{4'b0011, 4'b0000, 4'b0001};
    tbl[11] = '{4'b0011, 4'b0000, 4'b0010};
    tbl[12] = '{4'b0100, 4'b0100, 4'b0100};
    tbl[13] = '{4'b0000, 4'b0000, 4'b0000};
    tbl[14] = '{4'b0110, 4'b0000, 4'b0010};
    tbl[15] = '{4'b0100, 4'b0100, 4'b0100};
    tbl[16] = '{4'b1000, 4'b0000, 4'b1000};
    tbl[17] = '{4'b0100, 4'b0000, 4'b0100};

    rst = 1'b1; req = '0; req_lock = '0; req_sub = '0; req_a = '0; req_b = '0;
    @(posedge clk); #1;
    cycle('0, '0, 1'b1, '0, 1'b1);
    cycle('0, '0, 1'b1, '0, 1'b1);
    idle(2);

    // Single requester: 1.0 + 2.0 = 3.0.
    req_a[31:0] = 32'h3F80_0000; req_b[31:0] = 32'h4000_0000; req_sub[0] = 1'b0;
    cycle(4'b0001, '0, 1'b0, 4'b0001, 1'b1);
    idle(LAT - 1);
    req = '0;
    #2;
    chk("single_val", 32'(rsp_val), 32'h1);
    chk("single_data", rsp_data, 32'h4040_0000);
    chk("single_busy", 32'(busy), 32'h1);
    idle(2);
    chk("single_busy_end", 32'(busy), 32'h0);

    // Fixed operands per requester for the table phase.
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = r2f(real'(i + 1));
      req_b[32*i +: 32] = r2f(real'(10 * (i + 1)));
      req_sub[i] = i[0];
    end
    cycle('0, '0, 1'b1, '0, 1'b1);
    for (int i = 0; i < 18; i++) cycle(tbl[i].r, tbl[i].lk, 1'b0, tbl[i].g, 1'b1);
    idle(LAT + 1);

    // Reset one cycle before the first result: all in-flight tags must vanish.
    cycle(4'b0001, '0, 1'b0, 4'b0001, 1'b1);
    cycle(4'b0010, '0, 1'b0, 4'b0010, 1'b1);
    cycle(4'b0100, '0, 1'b0, 4'b0100, 1'b1);
    idle(LAT - 4);
    cycle('0, '0, 1'b1, '0, 1'b1);
    for (int i = 0; i < 2 * LAT; i++) begin
      cycle('0, '0, 1'b0, '0, 1'b0);
      chk("post_rst_busy", 32'(busy), 32'h0);
    end

`ifdef FP_ADD_ARB_STATS_EN
    for (int i = 0; i < 10; i++) cycle(4'b0011, '0, 1'b0, '0, 1'b0);
    chk("issue_cnt", issue_cnt, 32'd10);
    chk("stall_cnt", stall_cnt, 32'd10);
    idle(LAT + 3);
    chk("issue_cnt_hold", issue_cnt, 32'd10);
    chk("stall_cnt_hold", stall_cnt, 32'd10);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] r, lk;
      for (int j = 0; j < N; j++) begin
        req_a[32*j +: 32] = r2f(real'($urandom_range(0, 1000)));
        req_b[32*j +: 32] = r2f(real'($urandom_range(0, 1000)));
        req_sub[j] = 1'($urandom_range(0, 1));
        lk[j] = ($urandom_range(0, 3) == 0);
      end
      r = N'($urandom);
      cycle(r, lk, 1'b0, '0, 1'b0);
    end
    idle(LAT + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp_add_arbiter.md
Name: fp_add_arbiter

Overview:
- Shares one pipelined fp_add unit between N_REQ requesters, e.g. several fragment_generator instances or a setup engine.
- Round-robin arbitration with an optional per-requester lock, so a requester can issue back-to-back dependent sequences.
- Tracks in-flight operations in a LAT-deep tag shift pipeline and routes each result to its owner.
- Sits between the requesters and the single fp_add instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- LAT, `FP_ADD_LAT, fp_add latency in cycles from en to valid y (≥1).
- ID_W, $clog2(N_REQ), requester tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req  in  N_REQ  per-requester operation request.
- req_lock  in  N_REQ  requester asks to keep grant next cycle.
- req_a  in  32*N_REQ  operand A, slice i belongs to requester i.
- req_b  in  32*N_REQ  operand B, slice i.
- req_sub  in  N_REQ  subtract select (a-b).
- gnt  out  N_REQ  one-hot grant, combinational, same cycle as issue.
- rsp_val  out  N_REQ  one-hot result valid.
- rsp_data  out  32  result, broadcast to all requesters.
- rsp_id  out  ID_W  owner tag of the current result.
- add_a  out  32  fp_add operand A.
- add_b  out  32  fp_add operand B.
- add_sub  out  1  fp_add subtract.
- add_en  out  1  fp_add issue enable.
- add_y  in  32  fp_add result.
- busy  out  1  at least one operation in flight.

Behaviour:
- Reset: r_prio=0, r_locked=0, r_lock_id=0, tag pipe valids=0, gnt=0, rsp_val=0, busy=0, add_en=0.
- Arbitration is combinational each cycle:
  - If r_locked and req[r_lock_id]: grant r_lock_id.
  - Otherwise grant the first i with req[i] set, searching r_prio, r_prio+1, … mod N_REQ.
  - If no req: gnt=0, add_en=0. add_a/add_b/add_sub then hold the requester-0 slices; their value is don't-care.
- Issue:
  - add_en=|gnt; add_a/add_b/add_sub are muxed from the granted slice.
  - A requester holds req and its operands stable until it sees gnt; it may drop req the cycle after gnt.
  - At most one issue per cycle.
- Priority update on an issue by requester g:
  - r_prio <= (g+1) mod N_REQ, unless the grant came from a lock, in which case r_prio is unchanged.
  - r_locked <= req_lock[g]; r_lock_id <= g.
- Lock release:
  - With no issue, r_locked holds its value.
  - Lock auto-releases (r_locked <= 0) if the locked requester deasserts req while r_locked, so an idle locker cannot starve others.
- Tag pipe:
  - Stage 0 captures {add_en, g}; stages shift each cycle.
  - Stage LAT-1 output is registered into stage valid at cycle t+LAT.
  - Result for an issue at posedge t: rsp_val[id]=1, rsp_id=id, rsp_data=add_y during cycle t+LAT.
  - rsp_val is combinational from the final stage, one cycle wide, with no backpressure. Requesters must always accept.
- Throughput: 1 op/cycle sustained. Up to LAT ops in flight, any mix of owners. Results return in issue order.
- busy = OR of all tag-stage valids.
- Reset mid-operation: all in-flight tags are dropped, so no rsp_val ever fires for them. Adder outputs after reset are ignored.
- Simultaneous issue and result in the same cycle are independent; this is legal and must be supported.
- A requester with req and req_lock both set retains grant indefinitely. Fairness is the requester's responsibility; fragment_generator locks for at most 3 ops (w0,w1,w2).

Optional Feature:
- Macro: FP_ADD_ARB_STATS_EN.
- Defined:
  - Adds outputs stall_cnt[31:0] and issue_cnt[31:0], both reset to 0.
  - issue_cnt increments on every add_en.
  - stall_cnt increments every cycle where (req & ~gnt) != 0.
  - Both saturate at 32'hFFFFFFFF.
- Undefined: ports and counters are absent; there is no other behavioural difference.

Test Plan:
- Single requester: req[0] at cycle 5 with a=3F800000, b=40000000, sub=0 → gnt[0] at cycle 5, add_en=1; rsp_val[0]=1, rsp_data=40400000, rsp_id=0 at cycle 5+LAT; busy high cycles 6..5+LAT.
- All 4 req held continuously from reset release → grants 0,1,2,3,0,1… one per cycle; rsp_id sequence matches the grant sequence LAT cycles later.
- Req0 with lock, 3 ops, and req1 pending throughout → gnt[0] on 3 consecutive cycles, then gnt[1]; r_prio stays 1 across the locked grants.
- Req2 locks, then drops req for one cycle while req3 is asserted → lock released, gnt[3] next cycle.
- Issue 3 ops, then assert rst 1 cycle before the first result → no rsp_val for 2*LAT cycles; gnt=0; busy=0 after the reset cycle.
- STATS_EN: 2 requesters contend for 10 cycles → issue_cnt=10, stall_cnt=10; then idle → both counters hold.
